// File: rtl/axis_frame_arbiter_if.sv
// Bundled AXI-stream signals around the frame arbiter: PORTS source lanes, one muxed sink, status.
// The arbiter uses the slave modport; the environment driving sources and the sink uses master.
interface axis_frame_arbiter_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(PORTS)
);
  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [PORTS-1:0]            s_axis_tvalid;
  logic [PORTS-1:0]            s_axis_tready;
  logic [PORTS-1:0]            s_axis_tlast;
  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser;

  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic                        m_axis_tlast;
  logic [USER_WIDTH-1:0]       m_axis_tuser;
  logic [ID_WIDTH-1:0]         m_axis_tid;

  logic                        status_busy;
  logic                        status_frame_done;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           m_axis_tid, status_busy, status_frame_done
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
           m_axis_tid, status_busy, status_frame_done
  );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: 1-cycle grant latency, 0-cycle combinational data/ready path.
// Sink backpressure passes straight to the granted source only; the grant is held until its tlast transfers.
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  axis_frame_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(PORTS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_WIDTH-1:0] r_grant_idx;
  logic [ID_WIDTH-1:0] r_last_idx;
  logic                r_frame_done;
  logic [ID_WIDTH-1:0] w_winner;
  logic [ID_WIDTH-1:0] w_scan_idx;
  logic                w_any_req;
  logic                w_frame_end;

  // Scan from the farthest slot down so the nearest requester after last_idx wins.
  always_comb begin
    w_winner   = r_last_idx;
    w_scan_idx = r_last_idx;
    w_any_req  = |bus.s_axis_tvalid;
    for (int k = PORTS; k >= 1; k--) begin
      w_scan_idx = ID_WIDTH'((int'(r_last_idx) + k) % PORTS);
      if (bus.s_axis_tvalid[w_scan_idx]) begin
        w_winner = w_scan_idx;
      end
    end
  end

  assign w_frame_end = (r_state == ACTIVE) && bus.m_axis_tready &&
                       bus.s_axis_tvalid[r_grant_idx] && bus.s_axis_tlast[r_grant_idx];

  always_comb begin
    w_state_nxt       = r_state;
    bus.s_axis_tready = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = bus.s_axis_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    bus.m_axis_tuser  = bus.s_axis_tuser[r_grant_idx*USER_WIDTH +: USER_WIDTH];
    bus.m_axis_tlast  = bus.s_axis_tlast[r_grant_idx];
    bus.m_axis_tid    = r_grant_idx;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        bus.m_axis_tvalid              = bus.s_axis_tvalid[r_grant_idx];
        bus.s_axis_tready[r_grant_idx] = bus.m_axis_tready;
        if (w_frame_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_idx   <= LAST_RST;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_frame_end;
      if (r_state == IDLE && w_any_req) begin
        r_grant_idx <= w_winner;
      end
      if (w_frame_end) begin
        r_last_idx <= r_grant_idx;
      end
    end
  end

  assign bus.status_busy       = (r_state == ACTIVE);
  assign bus.status_frame_done = r_frame_done;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: single frame timing, contention, wrap-around,
// backpressure with valid gaps, asynchronous reset mid-frame, back-to-back single-beat frames.
module tb_axis_frame_arbiter;
  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int UW    = 1;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axis_frame_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IDW)) bus();

  axis_frame_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l, input logic u);
    bus.s_axis_tvalid[p]          = v;
    bus.s_axis_tdata[p*DW +: DW]  = d;
    bus.s_axis_tlast[p]           = l;
    bus.s_axis_tuser[p]           = u;
  endtask

  task automatic clear_all();
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    bus.s_axis_tuser  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Sources in mask send nbeats-beat frames continuously; data = {port, beat}.
  // seq holds the expected grant order, one nibble per frame, frame 0 in bits 3:0.
  task automatic run_frames(input logic [3:0] mask, input int nbeats, input int nframes,
                            input logic [31:0] seq, input string tag);
    int         beat[PORTS];
    int         frames = 0;
    int         ob     = 0;
    int         cyc    = 0;
    logic [3:0] took;
    for (int p = 0; p < PORTS; p++) beat[p] = 0;
    while (frames < nframes && cyc < 60) begin
      next_cycle();
      cyc++;
      for (int p = 0; p < PORTS; p++) begin
        if (mask[p]) drive(p, 1'b1, 8'((p << 4) | beat[p]), beat[p] == nbeats - 1, 1'(beat[p] % 2));
        else         drive(p, 1'b0, 8'h00, 1'b0, 1'b0);
      end
      mid();
      took = bus.s_axis_tvalid & bus.s_axis_tready;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        chk({tag, " tid"},   32'(bus.m_axis_tid),        32'(seq[4*frames +: 4]));
        chk({tag, " tag"},   32'(bus.m_axis_tdata[7:4]), 32'(seq[4*frames +: 4]));
        chk({tag, " beat"},  32'(bus.m_axis_tdata[3:0]), 32'(ob));
        chk({tag, " last"},  32'(bus.m_axis_tlast),      32'(ob == nbeats - 1));
        chk({tag, " ready"}, 32'(bus.s_axis_tready),     32'(1) << seq[4*frames +: 4]);
        if (ob == nbeats - 1) begin
          ob = 0;
          frames++;
        end else begin
          ob++;
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (took[p]) beat[p] = (beat[p] + 1) % nbeats;
      end
    end
    chk({tag, " frames"}, 32'(frames), 32'(nframes));
    next_cycle();
    clear_all();
    mid();
    chk({tag, " end busy"}, 32'(bus.status_busy),       32'd0);
    chk({tag, " end done"}, 32'(bus.status_frame_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_all();
    bus.m_axis_tready = 1'b0;
    #2;
    chk("rst tvalid", 32'(bus.m_axis_tvalid),     32'd0);
    chk("rst tready", 32'(bus.s_axis_tready),     32'd0);
    chk("rst tid",    32'(bus.m_axis_tid),        32'd0);
    chk("rst busy",   32'(bus.status_busy),       32'd0);
    chk("rst done",   32'(bus.status_frame_done), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Single source: port 2, 3 beats
    next_cycle(); drive(2, 1'b1, 8'h20, 1'b0, 1'b0); mid();
    chk("t1 c0 tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("t1 c0 busy",   32'(bus.status_busy),   32'd0);
    next_cycle(); mid();
    chk("t1 c1 tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("t1 c1 tid",    32'(bus.m_axis_tid),    32'd2);
    chk("t1 c1 data",   32'(bus.m_axis_tdata),  32'h20);
    chk("t1 c1 ready",  32'(bus.s_axis_tready), 32'b0100);
    next_cycle(); drive(2, 1'b1, 8'h21, 1'b0, 1'b1); mid();
    chk("t1 c2 data",   32'(bus.m_axis_tdata),  32'h21);
    chk("t1 c2 user",   32'(bus.m_axis_tuser),  32'd1);
    chk("t1 c2 last",   32'(bus.m_axis_tlast),  32'd0);
    next_cycle(); drive(2, 1'b1, 8'h22, 1'b1, 1'b0); mid();
    chk("t1 c3 data",   32'(bus.m_axis_tdata),  32'h22);
    chk("t1 c3 last",   32'(bus.m_axis_tlast),  32'd1);
    next_cycle(); drive(2, 1'b0, 8'h00, 1'b0, 1'b0); mid();
    chk("t1 c4 done",   32'(bus.status_frame_done), 32'd1);
    chk("t1 c4 busy",   32'(bus.status_busy),       32'd0);
    chk("t1 c4 tvalid", 32'(bus.m_axis_tvalid),     32'd0);
    next_cycle(); mid();
    chk("t1 c5 done",   32'(bus.status_frame_done), 32'd0);

    // Contention after reset: grant order 0,1,2,3,0
    do_reset();
    run_frames(4'b1111, 2, 5, 32'h0000_3210, "cont");

    // Wrap-around: make port 3 the last winner, then ports 1 and 3 together
    run_frames(4'b1000, 1, 1, 32'h0000_0003, "pre3");
    run_frames(4'b1010, 1, 2, 32'h0000_0031, "wrap");

    // Backpressure and valid gaps on port 0 while port 1 waits
    next_cycle(); drive(0, 1'b1, 8'h00, 1'b0, 1'b0); drive(1, 1'b1, 8'h10, 1'b1, 1'b0); mid();
    chk("bp idle ready", 32'(bus.s_axis_tready), 32'd0);
    next_cycle(); mid();
    chk("bp b0 tid",    32'(bus.m_axis_tid),    32'd0);
    chk("bp b0 data",   32'(bus.m_axis_tdata),  32'h00);
    chk("bp b0 ready",  32'(bus.s_axis_tready), 32'b0001);
    next_cycle(); drive(0, 1'b1, 8'h01, 1'b0, 1'b0); bus.m_axis_tready = 1'b0; mid();
    chk("bp stall1 ready",  32'(bus.s_axis_tready), 32'd0);
    chk("bp stall1 tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("bp stall1 data",   32'(bus.m_axis_tdata),  32'h01);
    next_cycle(); mid();
    chk("bp stall2 ready",  32'(bus.s_axis_tready), 32'd0);
    chk("bp stall2 busy",   32'(bus.status_busy),   32'd1);
    next_cycle(); bus.m_axis_tready = 1'b1; mid();
    chk("bp b1 ready",  32'(bus.s_axis_tready), 32'b0001);
    chk("bp b1 data",   32'(bus.m_axis_tdata),  32'h01);
    next_cycle(); drive(0, 1'b0, 8'h02, 1'b0, 1'b0); mid();
    chk("bp gap1 tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("bp gap1 busy",   32'(bus.status_busy),   32'd1);
    chk("bp gap1 ready",  32'(bus.s_axis_tready), 32'b0001);
    next_cycle(); mid();
    chk("bp gap2 tid",    32'(bus.m_axis_tid),    32'd0);
    chk("bp gap2 tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    next_cycle(); drive(0, 1'b1, 8'h02, 1'b0, 1'b0); mid();
    chk("bp b2 data",   32'(bus.m_axis_tdata),  32'h02);
    chk("bp b2 tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    next_cycle(); drive(0, 1'b1, 8'h03, 1'b1, 1'b0); mid();
    chk("bp b3 data",   32'(bus.m_axis_tdata),  32'h03);
    chk("bp b3 last",   32'(bus.m_axis_tlast),  32'd1);
    chk("bp b3 ready",  32'(bus.s_axis_tready), 32'b0001);
    next_cycle(); drive(0, 1'b0, 8'h00, 1'b0, 1'b0); mid();
    chk("bp end done",  32'(bus.status_frame_done), 32'd1);
    chk("bp end ready", 32'(bus.s_axis_tready),     32'd0);
    next_cycle(); mid();
    chk("bp p1 tid",    32'(bus.m_axis_tid),    32'd1);
    chk("bp p1 ready",  32'(bus.s_axis_tready), 32'b0010);
    chk("bp p1 data",   32'(bus.m_axis_tdata),  32'h10);
    next_cycle(); drive(1, 1'b0, 8'h00, 1'b0, 1'b0); mid();
    chk("bp p1 done",   32'(bus.status_frame_done), 32'd1);

    // Asynchronous reset during beat 2 of a 5-beat frame from port 2
    next_cycle(); drive(2, 1'b1, 8'h20, 1'b0, 1'b0); mid();
    next_cycle(); mid();
    chk("rm b0 tid", 32'(bus.m_axis_tid), 32'd2);
    next_cycle(); drive(2, 1'b1, 8'h21, 1'b0, 1'b0); mid();
    next_cycle(); drive(2, 1'b1, 8'h22, 1'b0, 1'b0); mid();
    chk("rm b2 tvalid", 32'(bus.m_axis_tvalid), 32'd1);
    chk("rm b2 data",   32'(bus.m_axis_tdata),  32'h22);
    #1 rst = 1'b1;
    #1;
    chk("rm async tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rm async ready",  32'(bus.s_axis_tready), 32'd0);
    chk("rm async busy",   32'(bus.status_busy),   32'd0);
    chk("rm async tid",    32'(bus.m_axis_tid),    32'd0);
    clear_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle(); drive(3, 1'b1, 8'h30, 1'b1, 1'b0); drive(0, 1'b1, 8'h00, 1'b1, 1'b0); mid();
    chk("rm req idle", 32'(bus.m_axis_tvalid), 32'd0);
    next_cycle(); mid();
    chk("rm first tid",   32'(bus.m_axis_tid),    32'd0);
    chk("rm first ready", 32'(bus.s_axis_tready), 32'b0001);
    next_cycle(); drive(0, 1'b0, 8'h00, 1'b0, 1'b0); mid();
    chk("rm gap busy", 32'(bus.status_busy), 32'd0);
    next_cycle(); mid();
    chk("rm second tid",  32'(bus.m_axis_tid),   32'd3);
    chk("rm second data", 32'(bus.m_axis_tdata), 32'h30);
    next_cycle(); drive(3, 1'b0, 8'h00, 1'b0, 1'b0); mid();
    chk("rm second done", 32'(bus.status_frame_done), 32'd1);

    // Back-to-back single-beat frames from port 1: one idle cycle between beats
    begin
      int k = 0;
      next_cycle(); drive(1, 1'b1, 8'h40, 1'b1, 1'b0); mid();
      chk("sb c0 tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      for (int c = 1; c <= 7; c++) begin
        next_cycle(); drive(1, 1'b1, 8'(8'h40 + k), 1'b1, 1'b0); mid();
        chk($sformatf("sb c%0d tvalid", c), 32'(bus.m_axis_tvalid),     32'(c % 2 == 1));
        chk($sformatf("sb c%0d done", c),   32'(bus.status_frame_done), 32'(c % 2 == 0));
        if (c % 2 == 1) chk($sformatf("sb c%0d data", c), 32'(bus.m_axis_tdata), 32'(8'h40 + (c - 1) / 2));
        if (bus.s_axis_tvalid[1] && bus.s_axis_tready[1]) k++;
      end
      next_cycle(); drive(1, 1'b0, 8'h00, 1'b0, 1'b0); mid();
      chk("sb end done", 32'(bus.status_frame_done), 32'd1);
      chk("sb end busy", 32'(bus.status_busy),       32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
